// File: rtl/bsg_dlatch_en_reset.sv
// One register-file row: a width_p-wide latch that is transparent while en_i is high
// during the low phase of clk_i, with an asynchronous active-low clear.
module bsg_dlatch_en_reset #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Reset has priority, so an open latch is still forced to zero.
  always_latch begin
    if (!reset_n_i)
      data_o = '0;
    else if (en_i && !clk_i)
      data_o = data_i;
  end

endmodule

// File: rtl/bsg_mem_1r1w_dlatch.sv
// Latch-based 1R1W register file. Writes are staged in posedge flops and land in the
// addressed row during the following low phase; reads are registered, with an optional bypass.
module bsg_mem_1r1w_dlatch #(
  parameter  int width_p       = 32,
  parameter  int els_p         = 16,
  parameter  int read_bypass_p = 0,
  localparam int lg_els_lp     = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 w_v_i,
  input  logic [lg_els_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic                 r_v_i,
  input  logic [lg_els_lp-1:0] r_addr_i,
  output logic                 r_v_o,
  output logic [width_p-1:0]   r_data_o
);

  localparam logic [lg_els_lp:0] els_ext_lp = (lg_els_lp + 1)'(els_p);

  logic                 w_in_range;
  logic                 r_in_range;
  logic                 w_v_r;
  logic [lg_els_lp-1:0] w_addr_r;
  logic [width_p-1:0]   w_data_r;
  logic [width_p-1:0]   mem [els_p];
  logic [width_p-1:0]   rd_data;

  assign w_in_range = ({1'b0, w_addr_i} < els_ext_lp);
  assign r_in_range = ({1'b0, r_addr_i} < els_ext_lp);

  // Out-of-range writes never raise staging valid, so no row can open for them.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_r    <= 1'b0;
      w_addr_r <= '0;
      w_data_r <= '0;
    end else begin
      w_v_r <= w_v_i & w_in_range;
      if (w_v_i) begin
        w_addr_r <= w_addr_i;
        w_data_r <= w_data_i;
      end
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : row
    bsg_dlatch_en_reset #(
      .width_p (width_p)
    ) latch (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (w_v_r && (w_addr_r == lg_els_lp'(i))),
      .data_i    (w_data_r),
      .data_o    (mem[i])
    );
  end

  // The row latches are closed at the rising edge, so a same-cycle write is not yet visible.
  always_comb begin
    rd_data = '0;
    if (r_in_range)
      rd_data = mem[r_addr_i];
    if ((read_bypass_p != 0) && w_v_i && w_in_range && (w_addr_i == r_addr_i))
      rd_data = w_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v_o    <= 1'b0;
      r_data_o <= '0;
    end else begin
      r_v_o <= r_v_i;
      if (r_v_i)
        r_data_o <= rd_data;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!$isunknown(w_v_i) && !$isunknown(r_v_i))
        else $error("bsg_mem_1r1w_dlatch: unknown value on w_v_i or r_v_i");
      if ((w_v_i === 1'b1) && !w_in_range)
        $warning("bsg_mem_1r1w_dlatch: write address %0d out of range", w_addr_i);
      if ((r_v_i === 1'b1) && !r_in_range)
        $warning("bsg_mem_1r1w_dlatch: read address %0d out of range", r_addr_i);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_dlatch.sv
// Directed bench: two 12-entry instances (no bypass / bypass) driven in lockstep,
// checked against hand-computed table vectors plus reset and sweep sequences.
module tb_bsg_mem_1r1w_dlatch;

  localparam int W   = 32;
  localparam int ELS = 12;
  localparam int AW  = 4;

  typedef struct {
    logic          w_v;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_data;
    logic          r_v;
    logic [AW-1:0] r_addr;
    logic          exp_v;
    logic [W-1:0]  exp_a;
    logic [W-1:0]  exp_b;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic          w_v;
  logic [AW-1:0] w_addr;
  logic [W-1:0]  w_data;
  logic          r_v;
  logic [AW-1:0] r_addr;
  logic          r_v_a;
  logic [W-1:0]  r_data_a;
  logic          r_v_b;
  logic [W-1:0]  r_data_b;

  int checks;
  int passes;

  bsg_mem_1r1w_dlatch #(.width_p(W), .els_p(ELS), .read_bypass_p(0)) dut_a (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .w_v_i     (w_v),
    .w_addr_i  (w_addr),
    .w_data_i  (w_data),
    .r_v_i     (r_v),
    .r_addr_i  (r_addr),
    .r_v_o     (r_v_a),
    .r_data_o  (r_data_a)
  );

  bsg_mem_1r1w_dlatch #(.width_p(W), .els_p(ELS), .read_bypass_p(1)) dut_b (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .w_v_i     (w_v),
    .w_addr_i  (w_addr),
    .w_data_i  (w_data),
    .r_v_i     (r_v),
    .r_addr_i  (r_addr),
    .r_v_o     (r_v_b),
    .r_data_o  (r_data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                              input logic rv, input logic [AW-1:0] ra,
                              input logic ev, input logic [W-1:0] ea, input logic [W-1:0] eb);
    vec_t v;
    v.w_v = wv; v.w_addr = wa; v.w_data = wd;
    v.r_v = rv; v.r_addr = ra;
    v.exp_v = ev; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // Drive one cycle of requests, then sample just after the rising edge that takes them.
  task automatic apply_stimulus(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                                input logic rv, input logic [AW-1:0] ra);
    w_v = wv; w_addr = wa; w_data = wd;
    r_v = rv; r_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic ev,
                              input logic [W-1:0] ea, input logic [W-1:0] eb);
    checks++;
    if (r_v_a === ev && r_data_a === ea) passes++;
    else $display("[TB] FAIL %s nobypass: got v=%0b d=%h, want v=%0b d=%h", name, r_v_a, r_data_a, ev, ea);
    checks++;
    if (r_v_b === ev && r_data_b === eb) passes++;
    else $display("[TB] FAIL %s bypass: got v=%0b d=%h, want v=%0b d=%h", name, r_v_b, r_data_b, ev, eb);
  endtask

  vec_t     vecs [14];
  logic [W-1:0] oor_exp [ELS];
  logic [W-1:0] sweep_val;

  initial begin
    checks = 0;
    passes = 0;
    reset_n = 1'b0;
    w_v = 1'b0; w_addr = '0; w_data = '0;
    r_v = 1'b0; r_addr = '0;

    vecs[0]  = mk(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 0, 32'h0, 32'h0);
    vecs[1]  = mk(0, 4'd0, 32'h0,        1, 4'd3, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[2]  = mk(0, 4'd0, 32'h0,        1, 4'd4, 1, 32'h0, 32'h0);
    vecs[3]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 0, 32'h0, 32'h0);
    vecs[4]  = mk(1, 4'd5, 32'h11111111, 0, 4'd0, 0, 32'h0, 32'h0);
    vecs[5]  = mk(1, 4'd5, 32'h22222222, 1, 4'd5, 1, 32'h11111111, 32'h22222222);
    vecs[6]  = mk(0, 4'd0, 32'h0,        1, 4'd5, 1, 32'h22222222, 32'h22222222);
    vecs[7]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 0, 32'h22222222, 32'h22222222);
    vecs[8]  = mk(1, 4'd0, 32'hA,        0, 4'd0, 0, 32'h22222222, 32'h22222222);
    vecs[9]  = mk(1, 4'd0, 32'hB,        1, 4'd0, 1, 32'hA, 32'hB);
    vecs[10] = mk(1, 4'd0, 32'hC,        1, 4'd0, 1, 32'hB, 32'hC);
    vecs[11] = mk(0, 4'd0, 32'h0,        1, 4'd0, 1, 32'hC, 32'hC);
    vecs[12] = mk(0, 4'd0, 32'h0,        1, 4'd0, 1, 32'hC, 32'hC);
    vecs[13] = mk(1, 4'd13, 32'hFFFFFFFF, 0, 4'd0, 0, 32'hC, 32'hC);

    for (int i = 0; i < ELS; i++) oor_exp[i] = 32'h0;
    oor_exp[0] = 32'hC;
    oor_exp[3] = 32'hDEADBEEF;
    oor_exp[5] = 32'h22222222;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_initial", 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;

    apply_stimulus(1, 4'd7, 32'h00000077, 0, 4'd0);
    check_output("idle_after_release", 1'b0, 32'h0, 32'h0);
    apply_stimulus(1, 4'd2, 32'h00000055, 1, 4'd7);
    check_output("pre_reset_read", 1'b1, 32'h77, 32'h77);

    // Entry 2 is open in this low phase when reset arrives.
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    w_v = 1'b1; w_addr = 4'd9; w_data = 32'h99;
    r_v = 1'b1; r_addr = 4'd7;
    #1;
    check_output("reset_async", 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check_output("reset_held", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    w_v = 1'b0; r_v = 1'b0;
    reset_n = 1'b1;

    apply_stimulus(0, 4'd0, 32'h0, 1, 4'd7);
    check_output("post_reset_entry7", 1'b1, 32'h0, 32'h0);
    apply_stimulus(0, 4'd0, 32'h0, 1, 4'd2);
    check_output("post_reset_entry2", 1'b1, 32'h0, 32'h0);
    apply_stimulus(0, 4'd0, 32'h0, 1, 4'd9);
    check_output("post_reset_entry9", 1'b1, 32'h0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].w_v, vecs[i].w_addr, vecs[i].w_data, vecs[i].r_v, vecs[i].r_addr);
      check_output($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_a, vecs[i].exp_b);
    end

    for (int i = 0; i < ELS; i++) begin
      apply_stimulus(0, 4'd0, 32'h0, 1, AW'(i));
      check_output($sformatf("oor_keep%0d", i), 1'b1, oor_exp[i], oor_exp[i]);
    end
    apply_stimulus(0, 4'd0, 32'h0, 1, 4'd13);
    check_output("oor_read13", 1'b1, 32'h0, 32'h0);

    for (int i = 0; i < ELS; i++) begin
      sweep_val = 32'(i) * 32'h01010101;
      apply_stimulus(1, AW'(i), sweep_val, 0, 4'd0);
    end
    for (int i = ELS - 1; i >= 0; i--) begin
      sweep_val = 32'(i) * 32'h01010101;
      apply_stimulus(0, 4'd0, 32'h0, 1, AW'(i));
      check_output($sformatf("sweep%0d", i), 1'b1, sweep_val, sweep_val);
    end
    apply_stimulus(0, 4'd0, 32'h0, 1, 4'd12);
    check_output("oor_read12", 1'b1, 32'h0, 32'h0);
    apply_stimulus(0, 4'd0, 32'h0, 0, 4'd0);
    check_output("idle_hold", 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bsg_mem_1r1w_dlatch.md
Name: bsg_mem_1r1w_dlatch

Overview:
- Latch-based 1-read/1-write register file, `els_p` entries × `width_p` bits.
- Successor to the single-row `bsg_dlatch`: generalised depth, per-entry write enable, async reset, registered read port with optional write-to-read bypass.
- Used where flop-based `bsg_mem_1r1w` area is too high: small config/scratch stores in cores and NoC routers.
- Entries are transparent-low latches, fed by posedge staging flops, so each entry's data is stable before the next rising edge.

Parameters:
- `width_p`, 32, data width per entry (≥1).
- `els_p`, 16, number of entries (≥2; need not be a power of 2).
- `read_bypass_p`, 0: 0 = read-before-write on same-cycle same-address collision; 1 = write data forwarded.
- `lg_els_lp`, `$clog2(els_p)`, derived address width (localparam, not user-set).

Ports:
- `clk_i` in 1: single clock. Rising edge samples requests; low phase opens entry latches.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `w_v_i` in 1: write request, sampled at posedge.
- `w_addr_i` in `lg_els_lp`: write entry index.
- `w_data_i` in `width_p`: write data.
- `r_v_i` in 1: read request, sampled at posedge.
- `r_addr_i` in `lg_els_lp`: read entry index.
- `r_v_o` out 1: read data valid, 1 cycle after accepted `r_v_i`.
- `r_data_o` out `width_p`: registered read data.

Behaviour:
- Reset (`reset_n_i`=0, async, immediate):
  - all entries = 0; staging valid = 0; `r_v_o` = 0; `r_data_o` = 0.
  - Reset dominates an open latch. While reset is held, writes and reads are ignored.
- Reset release:
  - takes effect with no glitch write; first write requires a posedge with `w_v_i`=1 after release.
  - Release mid-low-phase opens no latch.
- Write pipeline:
  - posedge N with `w_v_i`=1 and `w_addr_i` < `els_p` → staging flops capture `{1, addr, data}`.
  - Entry[addr] latch is transparent while `clk_i`=0 during cycle N, holds otherwise.
  - Staging valid drops at posedge N+1 if `w_v_i`=0.
  - Only the staged entry opens; all others hold.
- Write with `w_addr_i` ≥ `els_p`: ignored, no entry changes.
- Read:
  - posedge N with `r_v_i`=1 → `r_v_o`=1 and `r_data_o`=entry[`r_addr_i`] during cycle N+1.
  - `r_v_i`=0 → `r_v_o`=0 next cycle; `r_data_o` holds its previous value.
  - `r_addr_i` ≥ `els_p` → `r_data_o`=0, `r_v_o`=1.
- Write-to-read latency: write at posedge N is visible to a read sampled at posedge N+1, data out in cycle N+2.
- Collision (read and write same address, same posedge N):
  - `read_bypass_p`=0: `r_data_o` = old entry value.
  - `read_bypass_p`=1: `r_data_o` = `w_data_i`.
  - The entry is updated in both modes.
- Back-to-back writes to the same entry are legal; last write wins. Writes to different entries on consecutive cycles are independent.
- No internal FSM beyond staging valid. Throughput: 1 read + 1 write per cycle, no stalls, no ready signals.
- Assertions (sim only):
  - `w_addr_i`/`r_addr_i` in range when the matching `_v_i` is high (warning, not fatal).
  - X on `w_v_i`/`r_v_i` out of reset is an error.

Decomposition:
- No shared package needed.
- `lg_els_lp` is a local derived constant.
- Bypass mode is a plain parameter; no enum.
- Sub-module `bsg_dlatch_en_reset`: one `width_p` row, transparent when `en_i`=1 and `clk_i`=0, async active-low clear. Instantiated `els_p` times.
- Top level holds:
  - staging flops,
  - write-address decoder,
  - read mux + out-of-range zeroing,
  - bypass compare,
  - output flops.

Test Plan:
- Reset: assert `reset_n_i`=0 mid-low-phase with a write staged → all entries read 0; `r_v_o`=0 during reset and 1 cycle after the first read post-release.
- Basic: write entry 3 = 0xDEADBEEF at posedge 1; read addr 3 at posedge 2 → cycle 3 `r_v_o`=1, `r_data_o`=0xDEADBEEF. Read entry 4 → 0.
- Collision: entry 5 = 0x11111111; same posedge write 0x22222222 and read 5 → bypass_p=0 returns 0x11111111, bypass_p=1 returns 0x22222222. Next read returns 0x22222222 in both modes.
- Back-to-back: writes to entry 0 of 0xA, 0xB, 0xC on consecutive cycles; read entry 0 each cycle from cycle 2 → 0xA, 0xB, 0xC, 0xC.
- Full sweep: write `entry[i]`=`i*0x01010101` for all `els_p`, then read all in reverse → exact values; no cross-entry corruption.
- Out of range (`els_p`=12): write addr 13 = 0xFFFFFFFF, then read all 12 entries → unchanged; read addr 13 → 0 with `r_v_o`=1.
